// File: rtl/detector_jogada.sv
// Button front end for the game control unit: synchronizes and debounces the
// four player buttons and emits one jogada pulse per accepted one-hot press.
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] botoes,
    output logic       jogada,
    output logic [3:0] jogada_codigo,
    output logic [3:0] db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        FILTRA        = 4'd1,
        EMITE         = 4'd2,
        ESPERA_SOLTAR = 4'd3,
        FILTRA_SOLTAR = 4'd4
    } estado_t;

    estado_t       estado, prox;
    logic [3:0]    s1, botoes_s;
    logic [3:0]    candidato, cand_prox, codigo_prox;
    logic [CW-1:0] cnt, cnt_prox;
    logic          um_hot;

    assign um_hot = (botoes_s != 4'd0) && ((botoes_s & (botoes_s - 4'd1)) == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1            <= 4'd0;
            botoes_s      <= 4'd0;
            estado        <= OCIOSO;
            cnt           <= '0;
            candidato     <= 4'd0;
            jogada_codigo <= 4'd0;
        end else begin
            s1            <= botoes;
            botoes_s      <= s1;
            estado        <= prox;
            cnt           <= cnt_prox;
            candidato     <= cand_prox;
            jogada_codigo <= codigo_prox;
        end
    end

    always_comb begin
        prox        = estado;
        cnt_prox    = cnt;
        cand_prox   = candidato;
        codigo_prox = jogada_codigo;
        jogada      = 1'b0;
        db_estado   = estado;
        case (estado)
            OCIOSO: begin
                cnt_prox = '0;
                if (habilita && um_hot) begin
                    cand_prox = botoes_s;
                    prox      = FILTRA;
                end
            end
            FILTRA: begin
                // any change of the synchronized buttons throws the press away
                if (!habilita || botoes_s != candidato) begin
                    prox = OCIOSO;
                end else if (cnt == CNT_MAX) begin
                    prox        = EMITE;
                    codigo_prox = candidato;
                end else begin
                    cnt_prox = cnt + 1'b1;
                end
            end
            EMITE: begin
                jogada = 1'b1;
                prox   = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                cnt_prox = '0;
                if (botoes_s == 4'd0) prox = FILTRA_SOLTAR;
            end
            FILTRA_SOLTAR: begin
                if (botoes_s != 4'd0) begin
                    prox = ESPERA_SOLTAR;
                end else if (cnt == CNT_MAX) begin
                    prox = OCIOSO;
                end else begin
                    cnt_prox = cnt + 1'b1;
                end
            end
            default: begin
                prox      = OCIOSO;
                db_estado = 4'hF;
            end
        endcase
    end

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: expected pulse cycle and code are queued
// when a press is driven and compared when the DUT pulses jogada.
module tb_detector_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] botoes;
    logic       jogada;
    logic [3:0] jogada_codigo;
    logic [3:0] db_estado;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int pushed = 0;
    int seen = 0;

    typedef struct {
        int         at;
        logic [3:0] code;
    } exp_t;
    exp_t exp_q[$];

    detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
        .clock(clock),
        .reset(reset),
        .habilita(habilita),
        .botoes(botoes),
        .jogada(jogada),
        .jogada_codigo(jogada_codigo),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // call right after a negedge, before driving the press
    task automatic expect_at(input int lat, input logic [3:0] code);
        exp_t e;
        e.at   = cyc + lat;
        e.code = code;
        exp_q.push_back(e);
        pushed++;
    endtask

    always @(posedge clock) begin
        #1;
        if (!reset && jogada) begin
            seen++;
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", {31'd0, jogada}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_code", {28'd0, jogada_codigo}, {28'd0, e.code});
            end
        end
    end

    initial begin
        logic [3:0] seq[$];
        logic [3:0] last;

        reset = 1'b1;
        habilita = 1'b0;
        botoes = 4'd0;
        cycles(3);
        reset = 1'b0;
        cycles(1);
        chk("rst_jogada", {31'd0, jogada}, 32'd0);
        chk("rst_codigo", {28'd0, jogada_codigo}, 32'd0);
        chk("rst_estado", {28'd0, db_estado}, 32'd0);
        cycles(1);

        // clean press, tracking the state sequence
        habilita = 1'b1;
        expect_at(7, 4'b0010);
        botoes = 4'b0010;
        last = db_estado;
        seq.push_back(last);
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (db_estado != last) begin
                last = db_estado;
                seq.push_back(last);
            end
        end
        chk("seq_len", seq.size(), 32'd4);
        for (int i = 0; i < seq.size() && i < 4; i++)
            chk("seq_state", {28'd0, seq[i]}, i);
        botoes = 4'd0;
        cycles(12);
        chk("idle_after_release", {28'd0, db_estado}, 32'd0);

        // bouncing press
        for (int k = 0; k < 5; k++) begin
            if (k == 4) expect_at(7, 4'b0100);
            botoes = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            cycles(2);
        end
        cycles(15);
        botoes = 4'd0;
        cycles(12);

        // multiple buttons, then disabled input
        botoes = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            chk("multi_idle", {28'd0, db_estado}, 32'd0);
        end
        botoes = 4'd0;
        cycles(4);
        habilita = 1'b0;
        botoes = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            chk("disabled_idle", {28'd0, db_estado}, 32'd0);
        end
        habilita = 1'b1;
        expect_at(5, 4'b1000);
        cycles(15);
        botoes = 4'd0;
        cycles(12);

        // long hold, short release and re-press absorbed, then full re-arm
        expect_at(7, 4'b0001);
        botoes = 4'b0001;
        cycles(50);
        botoes = 4'd0;
        cycles(3);
        botoes = 4'b0001;
        cycles(20);
        chk("absorb_state", {28'd0, db_estado}, 32'd3);
        botoes = 4'd0;
        cycles(12);
        chk("rearm_idle", {28'd0, db_estado}, 32'd0);
        expect_at(7, 4'b0001);
        botoes = 4'b0001;
        cycles(15);
        botoes = 4'd0;
        cycles(12);

        // reset while filtering
        botoes = 4'b0010;
        cycles(5);
        chk("pre_rst_filtra", {28'd0, db_estado}, 32'd1);
        chk("pre_rst_codigo", {28'd0, jogada_codigo}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_f_estado", {28'd0, db_estado}, 32'd0);
        chk("rst_f_codigo", {28'd0, jogada_codigo}, 32'd0);
        botoes = 4'd0;
        cycles(2);
        reset = 1'b0;
        cycles(20);

        // reset while waiting for release
        expect_at(7, 4'b0100);
        botoes = 4'b0100;
        cycles(10);
        chk("pre_rst_espera", {28'd0, db_estado}, 32'd3);
        reset = 1'b1;
        #1;
        chk("rst_e_estado", {28'd0, db_estado}, 32'd0);
        chk("rst_e_codigo", {28'd0, jogada_codigo}, 32'd0);
        chk("rst_e_jogada", {31'd0, jogada}, 32'd0);
        botoes = 4'd0;
        cycles(2);
        reset = 1'b0;
        cycles(20);
        chk("final_idle", {28'd0, db_estado}, 32'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("pulse_count", seen, pushed);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Button-side producer of the `jogada` handshake consumed by the game control unit. Synchronizes and debounces the four player buttons. Accepts only a single-button (one-hot) press, and only while enabled. Emits a one-cycle `jogada` pulse with a stable `jogada_codigo`, then re-arms only after all buttons have been released and debounced. Sits between the board buttons and the datapath/control unit. It replaces the raw edge detector that previously fed `jogada`.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: number of consecutive stable cycles required to accept a press or a release. Legal range is ≥ 1.
- `clock`  in  1  system clock; all state changes occur on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- `habilita`  in  1  high while the control unit is waiting for a play (state `espera_jogada`); presses are ignored when low.
- `botoes`  in  4  raw asynchronous buttons, active-high.
- `jogada`  out  1  one-cycle pulse; a debounced one-hot press was accepted.
- `jogada_codigo`  out  4  one-hot code of the last accepted press; held until the next accepted press.
- `db_estado`  out  4  current FSM state code, for debug.

## Operation
- Input path:
  - Two-flip-flop synchronizer: `botoes` → `s1` → `botoes_s`.
  - The FSM uses only `botoes_s`.
- Internal registers:
  - `candidato[3:0]`: the press under test.
  - Counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1).
- States (`db_estado` code in parentheses):
  - `ocioso` (0): `cnt` := 0.
    - If `habilita` and `botoes_s` is exactly one-hot: `candidato` := `botoes_s`, go to `filtra`.
    - Zero buttons or multiple buttons: stay in `ocioso`.
  - `filtra` (1):
    - If `!habilita` or `botoes_s` ≠ `candidato`: go to `ocioso`.
    - Else if `cnt` == DEBOUNCE_CYCLES-1: go to `emite`.
    - Else `cnt` := `cnt`+1.
  - `emite` (2):
    - `jogada` = 1 (Moore output).
    - `jogada_codigo` is loaded from `candidato` on the edge entering `emite`.
    - Always goes to `espera_soltar` on the next edge.
  - `espera_soltar` (3): `cnt` := 0. If `botoes_s` == 0, go to `filtra_soltar`. `habilita` is ignored.
  - `filtra_soltar` (4):
    - If `botoes_s` ≠ 0: go to `espera_soltar`.
    - Else if `cnt` == DEBOUNCE_CYCLES-1: go to `ocioso`.
    - Else `cnt` := `cnt`+1.
  - Codes 5–15 are illegal. They go to `ocioso` next cycle, with `db_estado` = 15 while in them.
- Reset values: state `ocioso`, `jogada` = 0, `jogada_codigo` = 0000, `db_estado` = 0, `cnt` = 0, `candidato` = 0000, synchronizer flops = 0.
- Exactly one `jogada` pulse per physical press. A button held indefinitely never produces a second pulse.
- A second button pressed while the first is held is absorbed in `espera_soltar` or `filtra_soltar`. No pulse is produced until all buttons are released.
- Reset mid-operation: immediate return to `ocioso`. `jogada_codigo` is cleared, and any in-progress debounce is discarded.

## Timing
- Synchronizer latency: 2 edges.
- A clean one-hot press first seen at the `botoes` pin before edge 1:
  - `botoes_s` is valid after edge 2.
  - Entry to `filtra` occurs at edge 3.
  - Entry to `emite` occurs at edge 3+DEBOUNCE_CYCLES.
  - `jogada` is high for exactly the cycle following that edge.
- `jogada_codigo` changes only on the edge entering `emite`, so it is valid in the same cycle as `jogada`.
- Re-arm: after release, at least DEBOUNCE_CYCLES+2 edges are spent in `espera_soltar`/`filtra_soltar` before returning to `ocioso`.
- A bounce (any change of `botoes_s`) inside either filter restarts the debounce from the beginning.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset and clean press:
  - After reset, outputs are 0/0000/0.
  - `habilita` = 1, `botoes` = 0010 held for 20 cycles → `jogada` is high exactly once, 7 edges after the press.
  - `jogada_codigo` = 0010. `db_estado` sequence is 0,1,2,3.
- Bounce: `botoes` toggles 0100/0000 every 2 cycles for 10 cycles, then holds 0100 → a single pulse, timed 7 edges after the final stable edge; `jogada_codigo` = 0100.
- Multiple buttons and disabled input:
  - `botoes` = 0011 → no pulse; stays in state 0.
  - `habilita` = 0 with `botoes` = 1000 → no pulse.
  - Raising `habilita` while 1000 is still held → pulse, 4 edges later plus the filter entry.
- Hold and re-arm:
  - Hold 0001 for 50 cycles → one pulse.
  - Release for 3 cycles, press 0001 again → no new pulse until release has been stable for 4 cycles.
  - After a full re-arm, a press → second pulse.
- Reset mid-operation: assert `reset` while in `filtra` or `espera_soltar` → asynchronous return to state 0 with `jogada_codigo` = 0000, and no spurious pulse after deassertion.
